// File: rtl/alu_if.sv
// Operand/strobe/result bundle between the operand registers and the ALU.
// The master drives strobes and operands, and the ALU (slave) returns C.
interface alu_if;
   logic        AND;
   logic        OR;
   logic        ADD;
   logic        SUB;
   logic        MUL;
   logic        DIV;
   logic        SHR;
   logic        SHL;
   logic        ROR;
   logic        ROL;
   logic        NEG;
   logic        NOT;
   logic [31:0] A;
   logic [31:0] B;
   logic [63:0] C;

   modport master (
      output AND, OR, ADD, SUB,
      output MUL, DIV, SHR, SHL,
      output ROR, ROL, NEG, NOT,
      output A, B,
      input  C
   );

   modport slave (
      input  AND, OR, ADD, SUB,
      input  MUL, DIV, SHR, SHL,
      input  ROR, ROL, NEG, NOT,
      input  A, B,
      output C
   );
endinterface

// File: rtl/alu.sv
// 32-bit ALU with a combinational datapath and one registered 64-bit result.
// Products fill C fully. A divide returns {remainder, quotient}.
module alu (
   input  logic clk,
   input  logic rst_n,
   alu_if.slave bus
);

   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  sh;

   assign a  = bus.A;
   assign b  = bus.B;
   assign sh = b[4:0];

   logic [31:0] and_r;
   logic [31:0] or_r;
   logic [31:0] add_r;
   logic [31:0] sub_r;
   logic [31:0] shr_r;
   logic [31:0] shl_r;
   logic [31:0] ror_r;
   logic [31:0] rol_r;
   logic [31:0] neg_r;
   logic [31:0] not_r;

   assign and_r = a & b;
   assign or_r  = a | b;
   assign add_r = a + b;
   assign sub_r = a - b;
   assign shr_r = a >> sh;
   assign shl_r = a << sh;
   assign neg_r = ~b + 32'd1;
   assign not_r = ~b;

   // Rotates shift a doubled copy so a zero amount needs no special case
   logic [63:0] aa;
   logic [63:0] ror_w;
   logic [63:0] rol_w;

   assign aa    = {a, a};
   assign ror_w = aa >> sh;
   assign rol_w = aa << sh;
   assign ror_r = ror_w[31:0];
   assign rol_r = rol_w[63:32];

   logic signed [63:0] sa64;
   logic signed [63:0] sb64;
   logic [63:0]        mul_r;

   assign sa64  = {{32{a[31]}}, a};
   assign sb64  = {{32{b[31]}}, b};
   assign mul_r = sa64 * sb64;

   // Signed divide on magnitudes; -2^31 / -1 wraps to 32'h80000000
   logic        a_neg;
   logic        b_neg;
   logic        b_zero;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_div;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [63:0] div_r;

   assign a_neg  = a[31];
   assign b_neg  = b[31];
   assign b_zero = (b == 32'd0);
   assign a_mag  = a_neg ? (~a + 32'd1) : a;
   assign b_mag  = b_neg ? (~b + 32'd1) : b;
   assign b_div  = b_zero ? 32'd1 : b_mag;
   assign q_mag  = a_mag / b_div;
   assign r_mag  = a_mag % b_div;
   assign quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
   assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
   assign div_r  = b_zero ? {a, 32'hFFFF_FFFF} : {rem, quo};

   logic [63:0] c_d;
   logic [63:0] c_q;

   // Case order is the strobe priority; no strobe holds C
   always_comb begin
      c_d = c_q;
      case (1'b1)
         bus.AND: c_d = {32'd0, and_r};
         bus.OR:  c_d = {32'd0, or_r};
         bus.ADD: c_d = {32'd0, add_r};
         bus.SUB: c_d = {32'd0, sub_r};
         bus.MUL: c_d = mul_r;
         bus.DIV: c_d = div_r;
         bus.SHR: c_d = {32'd0, shr_r};
         bus.SHL: c_d = {32'd0, shl_r};
         bus.ROR: c_d = {32'd0, ror_r};
         bus.ROL: c_d = {32'd0, rol_r};
         bus.NEG: c_d = {32'd0, neg_r};
         bus.NOT: c_d = {32'd0, not_r};
         default: c_d = c_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q <= 64'd0;
      end else begin
         c_q <= c_d;
      end
   end

   assign bus.C = c_q;

endmodule

// File: tb/tb_alu.sv
// Directed and random checks of alu against an arithmetic reference model.
module tb_alu;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [63:0] exp_c;

   alu_if bus ();

   alu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [11:0] S_AND = 12'h001;
   localparam logic [11:0] S_OR  = 12'h002;
   localparam logic [11:0] S_ADD = 12'h004;
   localparam logic [11:0] S_SUB = 12'h008;
   localparam logic [11:0] S_MUL = 12'h010;
   localparam logic [11:0] S_DIV = 12'h020;
   localparam logic [11:0] S_SHR = 12'h040;
   localparam logic [11:0] S_SHL = 12'h080;
   localparam logic [11:0] S_ROR = 12'h100;
   localparam logic [11:0] S_ROL = 12'h200;
   localparam logic [11:0] S_NEG = 12'h400;
   localparam logic [11:0] S_NOT = 12'h800;

   task automatic drive(input logic [11:0] s, input logic [31:0] a,
                        input logic [31:0] b);
      bus.AND = s[0];
      bus.OR  = s[1];
      bus.ADD = s[2];
      bus.SUB = s[3];
      bus.MUL = s[4];
      bus.DIV = s[5];
      bus.SHR = s[6];
      bus.SHL = s[7];
      bus.ROR = s[8];
      bus.ROL = s[9];
      bus.NEG = s[10];
      bus.NOT = s[11];
      bus.A   = a;
      bus.B   = b;
   endtask

   task automatic check(input string tag, input logic [63:0] exp);
      checks++;
      assert (bus.C === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, bus.C, exp);
      end
   endtask

   // Reference: pick highest-priority strobe, compute with 64-bit integers
   function automatic logic [63:0] ref_op(input logic [11:0] s,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [63:0] prev);
      longint sa, sb, q, r;
      logic [63:0] ua;
      logic [63:0] m;
      int k, n;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      m  = 64'h0000_0000_FFFF_FFFF;
      n  = int'(b & 32'd31);
      k  = -1;
      for (int i = 0; i < 12; i++)
         if (s[i] && k < 0) k = i;
      case (k)
         0: return {32'd0, a & b};
         1: return {32'd0, a | b};
         2: return (ua + {32'd0, b}) & m;
         3: return (ua - {32'd0, b}) & m;
         4: return sa * sb;
         5: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         6: return ua >> n;
         7: return (ua << n) & m;
         8: return ((ua >> n) | (ua << (32 - n))) & m;
         9: return ((ua << n) | (ua >> (32 - n))) & m;
         10: return (64'd0 - {32'd0, b}) & m;
         11: return {32'd0, ~b};
         default: return prev;
      endcase
   endfunction

   task automatic step(input string tag, input logic [11:0] s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
      @(negedge clk);
      drive(s, a, b);
      @(posedge clk);
      #1;
      check(tag, exp);
      exp_c = exp;
   endtask

   initial begin
      logic [11:0] s;
      logic [31:0] a, b;
      checks = 0;
      errors = 0;
      exp_c  = 64'd0;
      rst_n  = 1'b0;
      drive(12'd0, 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_init", 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      step("and", S_AND, 32'd3, 32'd4, 64'd0);
      step("or",  S_OR,  32'd3, 32'd4, 64'd7);
      step("add", S_ADD, 32'd3, 32'd4, 64'd7);
      step("sub", S_SUB, 32'd3, 32'd4, 64'h0000_0000_FFFF_FFFF);
      step("mul", S_MUL, 32'd3, 32'd4, 64'd12);
      step("div", S_DIV, 32'd3, 32'd4, 64'h0000_0003_0000_0000);
      step("shl", S_SHL, 32'd3, 32'd4, 64'd48);
      step("shr", S_SHR, 32'd3, 32'd4, 64'd0);
      step("neg", S_NEG, 32'd3, 32'd4, 64'h0000_0000_FFFF_FFFC);
      step("not", S_NOT, 32'd3, 32'd4, 64'h0000_0000_FFFF_FFFB);

      // asynchronous reset mid-cycle with C nonzero
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_async", 64'd0);
      drive(12'd0, 32'd3, 32'd4);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_release", 64'd0);
      exp_c = 64'd0;

      step("mul_neg", S_MUL, -32'sd2, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
      step("div_neg", S_DIV, -32'sd7, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
      step("div_zero", S_DIV, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF);
      step("div_ovf", S_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h0000_0000_8000_0000);
      step("ror", S_ROR, 32'h8000_0001, 32'd1, 64'h0000_0000_C000_0000);
      step("rol", S_ROL, 32'h8000_0001, 32'd1, 64'h0000_0000_0000_0003);
      step("ror_b21", S_ROR, 32'h8000_0001, 32'h21, 64'h0000_0000_C000_0000);
      step("shl_b21", S_SHL, 32'h8000_0001, 32'h21, 64'h0000_0000_0000_0002);
      step("rol_0", S_ROL, 32'h1234_5678, 32'h20, 64'h0000_0000_1234_5678);
      step("add_wrap", S_ADD, 32'hFFFF_FFFF, 32'd1, 64'd0);
      step("neg_min", S_NEG, 32'd5, 32'h8000_0000, 64'h0000_0000_8000_0000);
      step("mul_wide", S_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
           64'h3FFF_FFFF_0000_0001);
      for (int i = 0; i < 5; i++)
         step("idle_hold", 12'd0, $urandom, $urandom, 64'h3FFF_FFFF_0000_0001);
      step("prio_add_sub", S_ADD | S_SUB, 32'd3, 32'd4, 64'd7);

      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: s = 12'd1 << $urandom_range(0, 11);
            1: s = 12'($urandom);
            2: s = 12'd0;
            default: s = 12'd1 << $urandom_range(4, 5);
         endcase
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
         step("random", s, a, b, ref_op(s, a, b, exp_c));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
